// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller.
// - intc_reg_e      : register offsets within the controller's bus window
// - cause_t         : layout of the CAUSE register
// - CAUSE_VALID_BIT : bit position of the CAUSE valid flag
package intc_pkg;

   typedef enum logic [2:0] {
      REG_PENDING = 3'd0,
      REG_ENABLE  = 3'd1,
      REG_EDGE    = 3'd2,
      REG_CAUSE   = 3'd3,
      REG_SET     = 3'd4
   } intc_reg_e;

   typedef struct packed {
      logic        valid;
      logic [25:0] rsvd;
      logic [4:0]  idx;
   } cause_t;

   localparam int CAUSE_VALID_BIT = 31;

endpackage

// File: rtl/intc_sync.sv
// One-bit synchronizer for a single interrupt source.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   src      : raw asynchronous request line
//   sync     : synchronized level (second flop)
//   rise     : one-cycle pulse when the synchronized level goes 0 -> 1
module intc_sync (
   input  logic clk,
   input  logic rst,
   input  logic src,
   output logic sync,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // s3 clears on reset, so a line held high across reset release
   // is seen as a fresh rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= src;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign sync = s2;
   assign rise = s2 & ~s3;

endmodule

// File: rtl/intc.sv
// Memory-mapped interrupt controller.
// Synchronizes NUM_SRC request lines, latches them into PENDING (edge or
// level mode per source), and raises irq while any enabled source is pending.
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   src           : asynchronous interrupt request lines
//   cs, rd, wr    : bus chip select and strobes
//   addr          : register offset (see intc_reg_e)
//   data_in       : write data
//   data_out      : combinational read data, 0 unless cs & rd
//   irq           : interrupt request to the control unit
module intc
   import intc_pkg::*;
#(
   parameter int          NUM_SRC  = 8,
   parameter int unsigned EDGE_RST = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src,
   input  logic               cs,
   input  logic               rd,
   input  logic               wr,
   input  logic [2:0]         addr,
   input  logic [31:0]        data_in,
   output logic [31:0]        data_out,
   output logic               irq
);

   localparam logic [NUM_SRC-1:0] EDGE_INIT = NUM_SRC'(EDGE_RST);

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] edge_mode;
   logic [NUM_SRC-1:0] sync;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] active;
   logic [NUM_SRC-1:0] wdata;
   logic [NUM_SRC-1:0] set_bits;
   logic [NUM_SRC-1:0] clr_bits;
   logic [NUM_SRC-1:0] pending_nxt;
   logic               wr_en;
   logic               rd_en;
   intc_reg_e          reg_sel;
   cause_t             cause;
   logic               unused_data_hi;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      intc_sync u_sync (
         .clk  (clk),
         .rst  (rst),
         .src  (src[i]),
         .sync (sync[i]),
         .rise (rise[i])
      );
   end

   assign wr_en   = cs & wr;
   assign rd_en   = cs & rd;
   assign reg_sel = intc_reg_e'(addr);
   assign wdata   = data_in[NUM_SRC-1:0];

   // Register bits above NUM_SRC do not exist; their write data is dropped.
   assign unused_data_hi = ^data_in[31:NUM_SRC];

   assign set_bits = (wr_en && reg_sel == REG_SET)     ? wdata : '0;
   assign clr_bits = (wr_en && reg_sel == REG_PENDING) ? wdata : '0;

   // Edge sources accumulate (hardware rise or software SET win over W1C);
   // level sources simply follow the synchronized line.
   always_comb begin
      pending_nxt = (edge_mode & (rise | set_bits | (pending & ~clr_bits)))
                  | (~edge_mode & sync);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending   <= '0;
         enable    <= '0;
         edge_mode <= EDGE_INIT;
      end else begin
         pending <= pending_nxt;
         if (wr_en && reg_sel == REG_ENABLE) begin
            enable <= wdata;
         end
         if (wr_en && reg_sel == REG_EDGE) begin
            edge_mode <= wdata;
         end
      end
   end

   assign active = pending & enable;
   assign irq    = |active;

   // Lowest active index wins: scan from the top so the lowest hit is
   // the last assignment.
   always_comb begin
      cause       = '0;
      cause.valid = |active;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            cause.idx = 5'(i);
         end
      end
   end

   // Reads are combinational because the control unit loads data_out in
   // the same cycle it asserts rd.
   always_comb begin
      data_out = '0;
      if (rd_en) begin
         case (reg_sel)
            REG_PENDING: data_out = 32'(pending);
            REG_ENABLE:  data_out = 32'(enable);
            REG_EDGE:    data_out = 32'(edge_mode);
            REG_CAUSE:   data_out = cause;
            default:     data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_intc.sv
// Self-checking bench for intc: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase against a reference model.
module tb_intc;
   import intc_pkg::*;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  src;
   logic          cs;
   logic          rd;
   logic          wr;
   logic [2:0]    addr;
   logic [31:0]   data_in;
   logic [31:0]   data_out;
   logic          irq;

   int total = 0;
   int bad   = 0;

   // Reference model state: register contents and the history of src
   // values sampled at the last three clock edges (index 0 = most recent).
   logic [N-1:0] m_pend;
   logic [N-1:0] m_en;
   logic [N-1:0] m_edge;
   logic [N-1:0] hist [3];

   typedef struct {
      logic        c;
      logic        r;
      logic        w;
      logic [2:0]  a;
      logic [31:0] d;
      logic [N-1:0] s;
      logic        ei;
      logic [31:0] ed;
   } vec_t;

   vec_t tbl[$];

   intc #(.NUM_SRC(N), .EDGE_RST(1)) dut (
      .clk      (clk),
      .rst      (rst),
      .src      (src),
      .cs       (cs),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      m_pend = '0;
      m_en   = '0;
      m_edge = N'(1);
      for (int i = 0; i < 3; i++) hist[i] = '0;
   endtask

   function automatic logic [31:0] modelCause();
      logic [N-1:0] act;
      logic [N-1:0] low;
      logic [31:0]  idx;
      act = m_pend & m_en;
      if (act == '0) return 32'h0;
      low = act & (~act + N'(1));
      idx = 0;
      for (int i = 0; i < N; i++) if (low[i]) idx = 32'(i);
      return (32'h1 << CAUSE_VALID_BIT) | idx;
   endfunction

   function automatic logic [31:0] modelRead();
      if (!(cs && rd)) return 32'h0;
      case (addr)
         3'd0:    return 32'(m_pend);
         3'd1:    return 32'(m_en);
         3'd2:    return 32'(m_edge);
         3'd3:    return modelCause();
         default: return 32'h0;
      endcase
   endfunction

   // What happens at a clock edge given the inputs currently driven.
   task automatic modelEdge();
      logic [N-1:0] lvl;
      logic [N-1:0] rs;
      logic [N-1:0] setv;
      logic [N-1:0] clrv;
      lvl  = hist[1];
      rs   = hist[1] & ~hist[2];
      setv = (cs && wr && addr == 3'd4) ? data_in[N-1:0] : '0;
      clrv = (cs && wr && addr == 3'd0) ? data_in[N-1:0] : '0;
      for (int i = 0; i < N; i++) begin
         if (m_edge[i]) begin
            if (rs[i] || setv[i])  m_pend[i] = 1'b1;
            else if (clrv[i])      m_pend[i] = 1'b0;
         end else begin
            m_pend[i] = lvl[i];
         end
      end
      if (cs && wr && addr == 3'd1) m_en   = data_in[N-1:0];
      if (cs && wr && addr == 3'd2) m_edge = data_in[N-1:0];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = src;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic exp_irq,
                              input logic [31:0] exp_data);
      checkVal({name, " irq"}, 32'(irq), 32'(exp_irq));
      checkVal({name, " data_out"}, data_out, exp_data);
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, |(m_pend & m_en), modelRead());
   endtask

   // Called at posedge+1; leaves time at the following negedge.
   task automatic applyStimulus(input logic c, input logic r, input logic w,
                                input logic [2:0] a, input logic [31:0] d,
                                input logic [N-1:0] s);
      cs      = c;
      rd      = r;
      wr      = w;
      addr    = a;
      data_in = d;
      src     = s;
      #4;
   endtask

   task automatic tick();
      modelEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic wrReg(input logic [2:0] a, input logic [31:0] d,
                        input logic [N-1:0] s);
      applyStimulus(1'b1, 1'b0, 1'b1, a, d, s);
      checkModel("model wr");
      tick();
   endtask

   task automatic rdReg(input string name, input logic [2:0] a,
                        input logic [N-1:0] s, input logic ei,
                        input logic [31:0] ed);
      applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0, s);
      checkOutput(name, ei, ed);
      checkModel({"model ", name});
      tick();
   endtask

   task automatic idle(input logic [N-1:0] s);
      applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, s);
      checkModel("model idle");
      tick();
   endtask

   task automatic addVec(input logic c, input logic r, input logic w,
                         input logic [2:0] a, input logic [31:0] d,
                         input logic [N-1:0] s, input logic ei,
                         input logic [31:0] ed);
      vec_t v;
      v.c = c; v.r = r; v.w = w; v.a = a; v.d = d; v.s = s;
      v.ei = ei; v.ed = ed;
      tbl.push_back(v);
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0;
      addr = 3'd0; data_in = 32'h0; src = '0;
      modelReset();

      // Reset state
      #12;
      cs = 1'b1; rd = 1'b1; addr = REG_PENDING; #1;
      checkOutput("reset pending", 1'b0, 32'h0);
      addr = REG_EDGE; #1;
      checkOutput("reset edge", 1'b0, 32'h1);
      @(posedge clk); #1;
      rst = 1'b0;

      // Edge flow, software trigger, address map, rd&wr, cs gating
      addVec(1,0,1, REG_ENABLE,  32'h01, 8'h00, 0, 32'h0);
      addVec(1,0,1, REG_EDGE,    32'h01, 8'h00, 0, 32'h0);
      addVec(0,0,0, 3'd0,        32'h0,  8'h01, 0, 32'h0);
      addVec(0,0,0, 3'd0,        32'h0,  8'h00, 0, 32'h0);
      addVec(0,0,0, 3'd0,        32'h0,  8'h00, 0, 32'h0);
      addVec(1,1,0, REG_PENDING, 32'h0,  8'h00, 1, 32'h1);
      addVec(1,1,0, REG_CAUSE,   32'h0,  8'h00, 1, 32'h80000000);
      addVec(1,0,1, REG_PENDING, 32'h01, 8'h00, 1, 32'h0);
      addVec(1,1,0, REG_PENDING, 32'h0,  8'h00, 0, 32'h0);
      addVec(1,0,1, REG_EDGE,    32'hFF, 8'h00, 0, 32'h0);
      addVec(1,0,1, REG_ENABLE,  32'h80, 8'h00, 0, 32'h0);
      addVec(1,0,1, REG_SET,     32'h80, 8'h00, 0, 32'h0);
      addVec(1,1,0, REG_PENDING, 32'h0,  8'h00, 1, 32'h80);
      addVec(0,1,0, REG_CAUSE,   32'h0,  8'h00, 1, 32'h0);
      addVec(1,0,1, REG_PENDING, 32'h80, 8'h00, 1, 32'h0);
      addVec(1,1,0, REG_PENDING, 32'h0,  8'h00, 0, 32'h0);
      addVec(1,1,1, REG_ENABLE,  32'h0F, 8'h00, 0, 32'h80);
      addVec(1,1,0, REG_ENABLE,  32'h0,  8'h00, 0, 32'h0F);
      addVec(1,0,1, REG_EDGE,    32'h00, 8'h00, 0, 32'h0);
      addVec(1,0,1, REG_SET,     32'h01, 8'h00, 0, 32'h0);
      addVec(1,1,0, REG_PENDING, 32'h0,  8'h00, 0, 32'h0);
      addVec(1,1,0, 3'd6,        32'h0,  8'h00, 0, 32'h0);
      addVec(0,0,1, REG_ENABLE,  32'hFF, 8'h00, 0, 32'h0);
      addVec(1,1,0, REG_ENABLE,  32'h0,  8'h00, 0, 32'h0F);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].c, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s);
         checkOutput($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ed);
         checkModel($sformatf("model vec%0d", i));
         tick();
      end

      // Level source
      wrReg(REG_ENABLE, 32'h04, 8'h04);
      idle(8'h04);
      idle(8'h04);
      rdReg("level cause", REG_CAUSE, 8'h04, 1'b1, 32'h80000002);
      wrReg(REG_PENDING, 32'h04, 8'h04);
      rdReg("level w1c", REG_PENDING, 8'h04, 1'b1, 32'h04);
      applyStimulus(0, 0, 0, 3'd0, 32'h0, 8'h00);
      checkOutput("level drop0", 1'b1, 32'h0); tick();
      applyStimulus(0, 0, 0, 3'd0, 32'h0, 8'h00);
      checkOutput("level drop1", 1'b1, 32'h0); tick();
      applyStimulus(0, 0, 0, 3'd0, 32'h0, 8'h00);
      checkOutput("level drop2", 1'b1, 32'h0); tick();
      applyStimulus(0, 0, 0, 3'd0, 32'h0, 8'h00);
      checkOutput("level drop3", 1'b0, 32'h0); tick();

      // Priority and masking
      wrReg(REG_EDGE, 32'hFF, 8'h00);
      wrReg(REG_ENABLE, 32'h20, 8'h00);
      idle(8'h28);
      idle(8'h00);
      idle(8'h00);
      rdReg("prio 5", REG_CAUSE, 8'h00, 1'b1, 32'h80000005);
      wrReg(REG_ENABLE, 32'h28, 8'h00);
      rdReg("prio 3", REG_CAUSE, 8'h00, 1'b1, 32'h80000003);
      wrReg(REG_ENABLE, 32'h00, 8'h00);
      rdReg("masked cause", REG_CAUSE, 8'h00, 1'b0, 32'h0);
      rdReg("masked pend", REG_PENDING, 8'h00, 1'b0, 32'h28);

      // Set beats clear
      idle(8'h02);
      idle(8'h00);
      idle(8'h00);
      rdReg("src1 pend", REG_PENDING, 8'h02, 1'b0, 32'h2A);
      idle(8'h00);
      wrReg(REG_PENDING, 32'h02, 8'h00);
      rdReg("set beats clr", REG_PENDING, 8'h00, 1'b0, 32'h2A);

      // Reset mid-operation
      wrReg(REG_ENABLE, 32'hFF, 8'hFF);
      wrReg(REG_SET, 32'hFF, 8'hFF);
      rdReg("all pend", REG_PENDING, 8'hFF, 1'b1, 32'hFF);
      applyStimulus(1, 1, 0, REG_PENDING, 32'h0, 8'hFF);
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkOutput("rst pend", 1'b0, 32'h0);
      addr = REG_ENABLE; #1;
      checkOutput("rst enable", 1'b0, 32'h0);
      addr = REG_EDGE; #1;
      checkOutput("rst edge", 1'b0, 32'h1);
      src = 8'h01;
      @(posedge clk); #1;
      rst = 1'b0;
      rdReg("post rst 0", REG_PENDING, 8'h01, 1'b0, 32'h0);
      rdReg("post rst 1", REG_PENDING, 8'h01, 1'b0, 32'h0);
      rdReg("post rst 2", REG_PENDING, 8'h01, 1'b0, 32'h0);
      rdReg("post rst 3", REG_PENDING, 8'h01, 1'b0, 32'h1);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         logic [N-1:0] flip;
         flip = N'($urandom) & N'($urandom) & N'($urandom);
         applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       3'($urandom_range(0, 7)), $urandom, src ^ flip);
         checkModel("rand");
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
